// File: rtl/ktc32_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ktc32_mem_pkg
//  Description : Shared size codes, FSM state encoding and the byte-mask
//                helper for the KTC32 memory-access unit.
//  Revision    : 1.0  initial release
// ============================================================================
package ktc32_mem_pkg;

    // Access size codes presented by the core (0 is illegal)
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    // Controller state encoding
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Right-aligned byte mask for an access size; size 3 spans the whole
    // bus when it is 64 bits wide (dword), otherwise four bytes.
    function automatic logic [7:0] size_mask(input logic [1:0] size, input logic wide);
        logic [7:0] m;
        case (size)
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            SZ_WORD: m = wide ? 8'hFF : 8'h0F;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ktc32_mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ktc32_core_if / ktc32_bus_if
//  Description : Core-side request/response bundle and bus-side
//                req/gnt/rvalid bundle of the KTC32 memory-access unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface ktc32_core_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [1:0]        core_size;
    logic              core_signed;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wd;
    logic [DATA_W-1:0] core_rd;
    logic              core_ready;
    logic              core_err;

    // The core issues requests
    modport master (
        output core_req, core_we, core_size, core_signed, core_addr, core_wd,
        input  core_rd, core_ready, core_err
    );

    // The access unit serves them
    modport slave (
        input  core_req, core_we, core_size, core_signed, core_addr, core_wd,
        output core_rd, core_ready, core_err
    );
endinterface

interface ktc32_bus_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_be;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_err;

    // The access unit drives requests onto the bus
    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    // The memory/slave answers them
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/ktc32_lane_steer.sv
`default_nettype none
// ============================================================================
//  Module      : ktc32_lane_steer
//  Description : Combinational byte-lane steering: byte enables and store
//                data shifted to the addressed lane, load data shifted back
//                down, masked to the access size and sign/zero extended.
//  Revision    : 1.0  initial release
// ============================================================================
module ktc32_lane_steer
    import ktc32_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W/8)
) (
    input  wire logic [1:0]          i_size,
    input  wire logic [LANE_W-1:0]   i_lane,
    input  wire logic                i_sign_ext,
    input  wire logic [DATA_W-1:0]   i_wd,
    input  wire logic [DATA_W-1:0]   i_rdata,
    output logic      [DATA_W/8-1:0] o_be,
    output logic      [DATA_W-1:0]   o_wdata,
    output logic      [DATA_W-1:0]   o_rd
);
    localparam int c_NB = DATA_W/8;

    logic [DATA_W-1:0] w_sh;

    assign o_be    = c_NB'(size_mask(i_size, DATA_W == 64) << i_lane);
    assign o_wdata = i_wd << {i_lane, 3'b000};

    // Bring the addressed lane down to bit 0, then mask and extend by size
    always_comb begin
        w_sh = i_rdata >> {i_lane, 3'b000};
        o_rd = '0;
        case (i_size)
            SZ_BYTE: o_rd = {{(DATA_W-8){i_sign_ext & w_sh[7]}}, w_sh[7:0]};
            SZ_HALF: o_rd = {{(DATA_W-16){i_sign_ext & w_sh[15]}}, w_sh[15:0]};
            SZ_WORD: o_rd = w_sh;
            default: o_rd = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ktc32_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ktc32_mem_access_unit
//  Description : Memory-access unit between the multi-cycle core and a
//                variable-latency req/gnt/rvalid bus, with lane steering,
//                load extension, misalignment detection and bus timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module ktc32_mem_access_unit
    import ktc32_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ktc32_core_if.slave    core,
    ktc32_bus_if.master    bus
);
    localparam int c_NB     = DATA_W/8;
    localparam int c_LANE_W = $clog2(c_NB);
    localparam int c_CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TO = c_CNT_W'(TIMEOUT);

    state_t              r_state;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wd;
    logic [DATA_W-1:0]   r_rd;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_misalign;
    logic                w_bad;
    logic                w_in_req;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_timeout;
    logic [c_NB-1:0]     w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rd;
    logic [DATA_W-1:0]   w_load;

    ktc32_lane_steer #(
        .DATA_W (DATA_W),
        .LANE_W (c_LANE_W)
    ) u_steer (
        .i_size     (r_size),
        .i_lane     (r_addr[c_LANE_W-1:0]),
        .i_sign_ext (r_signed),
        .i_wd       (r_wd),
        .i_rdata    (bus.bus_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rd       (w_rd)
    );

    // Alignment check on the incoming request (size 3 covers the full bus width)
    always_comb begin
        w_misalign = 1'b0;
        case (core.core_size)
            SZ_HALF: w_misalign = core.core_addr[0];
            SZ_WORD: w_misalign = |core.core_addr[c_LANE_W-1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_bad     = (core.core_size == 2'd0) || w_misalign;
    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == c_TO);
    // Stores complete with an all-zero read value
    assign w_load    = r_we ? '0 : w_rd;

    // Controller: latch the request, run the bus handshake, time out WAIT
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wd     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (core.core_req) begin
                        r_we     <= core.core_we;
                        r_size   <= core.core_size;
                        r_signed <= core.core_signed;
                        r_addr   <= core.core_addr;
                        r_wd     <= core.core_wd;
                        r_rd     <= '0;
                        r_state  <= w_bad ? ST_ERR : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_gnt) begin
                        r_cnt <= '0;
                        if (bus.bus_rvalid) begin
                            // Zero-latency slave: response arrives with the grant
                            if (bus.bus_err) begin
                                r_state <= ST_ERR;
                            end else begin
                                r_rd    <= w_load;
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_rvalid) begin
                        if (bus.bus_err) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_rd    <= w_load;
                            r_state <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  begin
                    r_rd    <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs are only non-zero while a request is being presented
    assign w_in_req       = (r_state == ST_REQ);
    assign bus.bus_req    = w_in_req;
    assign bus.bus_we     = w_in_req & r_we;
    assign bus.bus_addr   = w_in_req ? {r_addr[ADDR_W-1:c_LANE_W], {c_LANE_W{1'b0}}} : '0;
    assign bus.bus_be     = w_in_req ? w_be : '0;
    assign bus.bus_wdata  = w_in_req ? w_wdata : '0;

    assign core.core_ready = (r_state == ST_DONE) || (r_state == ST_ERR);
    assign core.core_err   = (r_state == ST_ERR);
    assign core.core_rd    = (r_state == ST_DONE) ? r_rd : '0;

endmodule
`default_nettype wire
